issue_y: RTL and testbench

Issue-side producer for the Y execution pipe. It accepts one decoded instruction per cycle from decode, reads operands from the register file, and applies a 4-slot destination scoreboard to detect RAW hazards against instructions still in flight in Y. Hazards resolve by stalling decode or, when compiled in, by forwarding from the Y writeback bus. Its registered outputs drive the `is_y_*` inputs of the Y pipe, and it snoops `y_wb_*` from the same pipe.

---
 rtl/issue_y_if.sv | 48 ++++
 rtl/issue_y.sv | 116 +++++++++++
 tb/tb_issue_y.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/issue_y_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_y_if : decode / register-file / Y-pipe signal bundle for issue_y    |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface issue_y_if;
  logic        id_is_valid;
  logic [4:0]  id_is_rs;
  logic [4:0]  id_is_rt;
  logic [4:0]  id_is_regdest;
  logic        id_is_writereg;
  logic        id_is_writeov;
  logic        is_id_stall;

  logic [4:0]  is_rf_addra;
  logic [4:0]  is_rf_addrb;
  logic [31:0] rf_is_dataa;
  logic [31:0] rf_is_datab;

  logic [4:0]  y_wb_regdest;
  logic        y_wb_writereg;
  logic [31:0] y_wb_wbvalue;

  logic [31:0] is_y_rega;
  logic [31:0] is_y_regb;
  logic [4:0]  is_y_regdest;
  logic        is_y_writereg;
  logic        is_y_writeov;

  modport slave (
    input  id_is_valid, id_is_rs, id_is_rt, id_is_regdest, id_is_writereg, id_is_writeov,
    output is_id_stall,
    output is_rf_addra, is_rf_addrb,
    input  rf_is_dataa, rf_is_datab,
    input  y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    output is_y_rega, is_y_regb, is_y_regdest, is_y_writereg, is_y_writeov
  );

  modport master (
    output id_is_valid, id_is_rs, id_is_rt, id_is_regdest, id_is_writereg, id_is_writeov,
    input  is_id_stall,
    input  is_rf_addra, is_rf_addrb,
    output rf_is_dataa, rf_is_datab,
    output y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    input  is_y_rega, is_y_regb, is_y_regdest, is_y_writereg, is_y_writeov
  );
endinterface
`default_nettype wire

// File: rtl/issue_y.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_y : Y-pipe issue stage with 4-slot RAW scoreboard                   |
// |           ISSUE_Y_BYPASS_EN enables forwarding from the Y writeback bus.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module issue_y (
  input  logic     clock,
  input  logic     reset,
  issue_y_if.slave bus
);
  localparam int c_SB_DEPTH = 4;

  logic [31:0] rega_q, rega_d;
  logic [31:0] regb_q, regb_d;
  logic [4:0]  regdest_q, regdest_d;
  logic        writereg_q, writereg_d;
  logic        writeov_q, writeov_d;

  // Slots P1..P3 only; P0 is derived from the is_y register itself
  logic [c_SB_DEPTH-1:1][4:0] sb_dest_q, sb_dest_d;
  logic [c_SB_DEPTH-1:1]      sb_pend_q, sb_pend_d;

  logic [c_SB_DEPTH-1:0][4:0] w_dest;
  logic [c_SB_DEPTH-1:0]      w_pend;
  logic                       w_haz_a, w_haz_b;
  logic                       w_stall, w_accept;
  logic [31:0]                w_opa, w_opb;

  always_comb begin
    w_dest = {sb_dest_q, regdest_q};
    w_pend = {sb_pend_q, (writereg_q | writeov_q) & (regdest_q != 5'd0)};
  end

  always_comb begin
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int k = 0; k < c_SB_DEPTH; k++) begin
      if (w_pend[k] && (w_dest[k] == bus.id_is_rs)) w_haz_a = 1'b1;
      if (w_pend[k] && (w_dest[k] == bus.id_is_rt)) w_haz_b = 1'b1;
    end
`ifndef ISSUE_Y_BYPASS_EN
    // Without forwarding the writeback cycle must also wait for the RF write
    if (bus.y_wb_writereg && (bus.y_wb_regdest == bus.id_is_rs)) w_haz_a = 1'b1;
    if (bus.y_wb_writereg && (bus.y_wb_regdest == bus.id_is_rt)) w_haz_b = 1'b1;
`endif
    if (bus.id_is_rs == 5'd0) w_haz_a = 1'b0;
    if (bus.id_is_rt == 5'd0) w_haz_b = 1'b0;
  end

  assign w_stall  = ~reset | (bus.id_is_valid & (w_haz_a | w_haz_b));
  assign w_accept = bus.id_is_valid & ~w_stall;

  always_comb begin
    w_opa = bus.rf_is_dataa;
    w_opb = bus.rf_is_datab;
`ifdef ISSUE_Y_BYPASS_EN
    if (bus.y_wb_writereg && (bus.y_wb_regdest == bus.id_is_rs)) w_opa = bus.y_wb_wbvalue;
    if (bus.y_wb_writereg && (bus.y_wb_regdest == bus.id_is_rt)) w_opb = bus.y_wb_wbvalue;
`endif
    if (bus.id_is_rs == 5'd0) w_opa = 32'd0;
    if (bus.id_is_rt == 5'd0) w_opb = 32'd0;
  end

`ifndef ISSUE_Y_BYPASS_EN
  logic w_unused_wb;
  assign w_unused_wb = ^bus.y_wb_wbvalue;
`endif

  always_comb begin
    rega_d     = 32'd0;
    regb_d     = 32'd0;
    regdest_d  = 5'd0;
    writereg_d = 1'b0;
    writeov_d  = 1'b0;
    if (w_accept) begin
      rega_d     = w_opa;
      regb_d     = w_opb;
      regdest_d  = bus.id_is_regdest;
      writereg_d = bus.id_is_writereg;
      writeov_d  = bus.id_is_writeov;
    end
    sb_dest_d = w_dest[c_SB_DEPTH-2:0];
    sb_pend_d = w_pend[c_SB_DEPTH-2:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rega_q     <= 32'd0;
      regb_q     <= 32'd0;
      regdest_q  <= 5'd0;
      writereg_q <= 1'b0;
      writeov_q  <= 1'b0;
      sb_dest_q  <= '0;
      sb_pend_q  <= '0;
    end else begin
      rega_q     <= rega_d;
      regb_q     <= regb_d;
      regdest_q  <= regdest_d;
      writereg_q <= writereg_d;
      writeov_q  <= writeov_d;
      sb_dest_q  <= sb_dest_d;
      sb_pend_q  <= sb_pend_d;
    end
  end

  assign bus.is_id_stall   = w_stall;
  assign bus.is_rf_addra   = bus.id_is_rs;
  assign bus.is_rf_addrb   = bus.id_is_rt;
  assign bus.is_y_rega     = rega_q;
  assign bus.is_y_regb     = regb_q;
  assign bus.is_y_regdest  = regdest_q;
  assign bus.is_y_writereg = writereg_q;
  assign bus.is_y_writeov  = writeov_q;
endmodule
`default_nettype wire

// File: tb/tb_issue_y.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_issue_y : directed + random bench for issue_y against an in-bench      |
// |              model of the scoreboard rules, Y pipe and register file.     |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_issue_y;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  issue_y_if bus();
  issue_y dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed { logic [4:0] dest; logic wr; logic ov; } instr_t;

  // hist[0] is the instruction on is_y now, hist[4] the one on y_wb now
  instr_t      hist [5];
  logic [31:0] rf [32];
  assign bus.rf_is_dataa = rf[bus.is_rf_addra];
  assign bus.rf_is_datab = rf[bus.is_rf_addrb];

  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;
  bit   fixed_wb = 1'b0;
  logic exp_stall = 1'b1;
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [4:0]  exp_d = '0;
  logic        exp_wr = 1'b0, exp_ov = 1'b0;
  logic        dut_stall_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic haz(input logic [4:0] s);
    logic h;
    h = 1'b0;
    if (s == 5'd0) return 1'b0;
    for (int k = 0; k < 4; k++)
      if ((hist[k].wr || hist[k].ov) && hist[k].dest == s) h = 1'b1;
`ifndef ISSUE_Y_BYPASS_EN
    if (bus.y_wb_writereg && bus.y_wb_regdest == s) h = 1'b1;
`endif
    return h;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
`ifdef ISSUE_Y_BYPASS_EN
    if (bus.y_wb_writereg && bus.y_wb_regdest == s) return bus.y_wb_wbvalue;
`endif
    return rf[s];
  endfunction

  // One clock cycle: drive the Y writeback from the model, predict, then commit after the edge
  task automatic cycle();
    logic        acc;
    logic [31:0] na, nb;
    bus.y_wb_regdest  = hist[4].dest;
    bus.y_wb_writereg = hist[4].wr | (hist[4].ov & (fixed_wb | ($urandom_range(1) == 1)));
    bus.y_wb_wbvalue  = fixed_wb ? 32'h1234_5678 : $urandom;
    exp_stall = !reset || (bus.id_is_valid && (haz(bus.id_is_rs) || haz(bus.id_is_rt)));
    @(negedge clock);
    dut_stall_s = bus.is_id_stall;
    acc = reset && bus.id_is_valid && !exp_stall;
    na  = acc ? opnd(bus.id_is_rs) : 32'd0;
    nb  = acc ? opnd(bus.id_is_rt) : 32'd0;
    @(posedge clock);
    #1;
    if (bus.y_wb_writereg && bus.y_wb_regdest != 5'd0) rf[bus.y_wb_regdest] = bus.y_wb_wbvalue;
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = acc ? instr_t'{bus.id_is_regdest, bus.id_is_writereg, bus.id_is_writeov} : instr_t'(0);
    exp_a  = na;
    exp_b  = nb;
    exp_d  = acc ? bus.id_is_regdest : 5'd0;
    exp_wr = acc & bus.id_is_writereg;
    exp_ov = acc & bus.id_is_writeov;
    if (!reset) begin
      for (int k = 0; k < 5; k++) hist[k] = '0;
      exp_a = '0; exp_b = '0; exp_d = '0; exp_wr = 1'b0; exp_ov = 1'b0;
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wr, input logic ov);
    bus.id_is_valid    = v;
    bus.id_is_rs       = rs;
    bus.id_is_rt       = rt;
    bus.id_is_regdest  = rd;
    bus.id_is_writereg = wr;
    bus.id_is_writeov  = ov;
  endtask

  task automatic drain();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle();
  endtask

  // Present a dependent instruction and count stall cycles until accepted (bounded)
  task automatic count_stalls(output int cnt);
    bit done;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle();
      if (dut_stall_s) cnt++;
      else done = 1'b1;
    end
  endtask

  always @(negedge clock) begin
    if (run) begin
      chk("stall",    32'(bus.is_id_stall),   32'(exp_stall));
      chk("addra",    32'(bus.is_rf_addra),   32'(bus.id_is_rs));
      chk("addrb",    32'(bus.is_rf_addrb),   32'(bus.id_is_rt));
      chk("rega",     bus.is_y_rega,          exp_a);
      chk("regb",     bus.is_y_regb,          exp_b);
      chk("regdest",  32'(bus.is_y_regdest),  32'(exp_d));
      chk("writereg", 32'(bus.is_y_writereg), 32'(exp_wr));
      chk("writeov",  32'(bus.is_y_writeov),  32'(exp_ov));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    for (int k = 0; k < 5; k++) hist[k] = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hFFFF_FFFF;
    bus.y_wb_regdest = '0; bus.y_wb_writereg = 1'b0; bus.y_wb_wbvalue = '0;

    // Reset held two cycles with a valid instruction presented
    reset = 1'b0;
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    cycle();
    run = 1'b1;
    cycle();
    chk("rst_stall",    32'(dut_stall_s),       32'd1);
    chk("rst_rega",     bus.is_y_rega,          32'd0);
    chk("rst_regdest",  32'(bus.is_y_regdest),  32'd0);
    chk("rst_writereg", 32'(bus.is_y_writereg), 32'd0);

    // Independent issue
    reset = 1'b1;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    cycle();
    chk("ind_stall",    32'(dut_stall_s),       32'd0);
    chk("ind_rega",     bus.is_y_rega,          32'd5);
    chk("ind_regb",     bus.is_y_regb,          32'd7);
    chk("ind_regdest",  32'(bus.is_y_regdest),  32'd3);
    chk("ind_writereg", 32'(bus.is_y_writereg), 32'd1);

    // RAW hazard on r3 against the producer just accepted
    fixed_wb = 1'b1;
    issue(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0);
    count_stalls(cnt);
`ifdef ISSUE_Y_BYPASS_EN
    chk("raw_stall_cycles", 32'(cnt), 32'd4);
`else
    chk("raw_stall_cycles", 32'(cnt), 32'd5);
`endif
    chk("raw_rega", bus.is_y_rega, 32'h1234_5678);
    fixed_wb = 1'b0;
    drain();

    // r0 never hazards and always reads as zero
    issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    cycle();
    issue(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    cycle();
    chk("r0_stall", 32'(dut_stall_s), 32'd0);
    chk("r0_rega",  bus.is_y_rega,    32'd0);
    chk("r0_regb",  bus.is_y_regb,    32'd0);
    drain();

    // Non-writing producer, then overflow-conditional producer
    issue(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
    cycle();
    issue(1'b1, 5'd4, 5'd0, 5'd7, 1'b1, 1'b0);
    cycle();
    chk("nowr_stall", 32'(dut_stall_s), 32'd0);
    drain();
    fixed_wb = 1'b1;
    issue(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
    cycle();
    issue(1'b1, 5'd4, 5'd0, 5'd7, 1'b1, 1'b0);
    count_stalls(cnt);
`ifdef ISSUE_Y_BYPASS_EN
    chk("ov_stall_cycles", 32'(cnt), 32'd4);
`else
    chk("ov_stall_cycles", 32'(cnt), 32'd5);
`endif
    fixed_wb = 1'b0;
    drain();

    // Reset in flight discards the pending hazard
    rf[3] = 32'hCAFE_0003;
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    cycle();
    reset = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle();
    reset = 1'b1;
    issue(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0);
    cycle();
    chk("rstmid_stall", 32'(dut_stall_s), 32'd0);
    chk("rstmid_rega",  bus.is_y_rega,    32'hCAFE_0003);

    // Random traffic; decode holds its inputs while stalled
    for (int n = 0; n < 3000; n++) begin
      if (!(exp_stall && bus.id_is_valid))
        issue($urandom_range(9) < 8, 5'($urandom_range(7)), 5'($urandom_range(7)),
              5'($urandom_range(7)), $urandom_range(3) != 0, $urandom_range(7) == 0);
      reset = ($urandom_range(199) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
